// File: rtl/uart_ram_pkg.sv
// Shared definitions for the UART receive-to-RAM controller.
package uart_ram_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CNT_W  = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_STOP   = ST_STOP,
    S_SETTLE = ST_SETTLE,
    S_WRITE  = ST_WRITE
  } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Loadable baud down-counter: tick while the count is 0, then reload one full bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  // Count down; an explicit load takes priority over the automatic reload at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt == '0) begin
      cnt <= CNT_W'(CLKS_PER_BIT - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_rx_ram_ctrl.sv
// Sequences an external 8N1 frame shift register and stores each good byte to RAM.
// Handshake: shift_en is a one-cycle strobe qualifying shift_bit; ram_we is a one-cycle
// strobe qualifying ram_addr/ram_data. Neither side can stall, so there is no ready.
module uart_rx_ram_ctrl
  import uart_ram_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int ADDR_W       = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              rx,
  input  logic              clear,
  input  logic [7:0]        frame_data,
  output logic              shift_en,
  output logic              shift_bit,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              busy,
  output logic              full,
  output logic              overflow,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t                 state;
  state_t                 state_nxt;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   armed;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   settle_cnt;
  logic                   baud_load;
  logic                   baud_tick;
  logic [ADDR_W-1:0]      addr;
  logic                   stop_bad;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (CLOCK_50),
    .rst      (reset),
    .load     (baud_load),
    .load_val (CNT_W'(CLKS_PER_BIT / 2)),
    .tick     (baud_tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  assign stop_bad = (state == S_STOP) && baud_tick && !rx_s;

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    baud_load = 1'b0;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    ram_we    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (armed && !rx_s) begin
          baud_load = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            shift_en  = 1'b1;
            shift_bit = 1'b0;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_en  = 1'b1;
          shift_bit = rx_s;
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          shift_en  = 1'b1;
          shift_bit = rx_s;
          state_nxt = rx_s ? S_SETTLE : S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        ram_we    = !full && !clear;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data-bit counter, only meaningful while in DATA.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                  bit_cnt <= '0;
    else if (state != S_DATA)   bit_cnt <= '0;
    else if (baud_tick)         bit_cnt <= bit_cnt + 1'b1;
  end

  // Two-cycle settle timer letting the shift register's registered output catch up.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                   settle_cnt <= 1'b0;
    else if (state == S_SETTLE)  settle_cnt <= ~settle_cnt;
    else                         settle_cnt <= 1'b0;
  end

  // Start detection is disarmed after a framing error until the line has been seen high (break handling).
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)         armed <= 1'b0;
    else if (stop_bad) armed <= 1'b0;
    else if (rx_s)     armed <= 1'b1;
  end

  // Capture the received byte at the end of SETTLE so it is stable through WRITE.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                ram_data <= '0;
    else if (state == S_SETTLE && settle_cnt) ram_data <= frame_data;
  end

  // Write address and sticky flags; clear overrides everything including a pending write.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear) begin
      addr      <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stop_bad) frame_err <= 1'b1;
      if (state == S_WRITE) begin
        if (full)                  overflow <= 1'b1;
        else if (addr == ADDR_MAX) full     <= 1'b1;
        else                       addr     <= addr + 1'b1;
      end
    end
  end

  assign ram_addr = addr;

endmodule

// File: tb/tb_uart_rx_ram_ctrl.sv
// Bench for uart_rx_ram_ctrl with a behavioural shift register and a frame-level RAM model.
module tb_uart_rx_ram_ctrl;

  localparam int CLKS  = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rx    = 1'b1;
  logic clear = 1'b0;
  logic [7:0]    frame_data;
  logic          shift_en, shift_bit, ram_we, busy, full, overflow, frame_err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;

  always #5 clk = ~clk;

  uart_rx_ram_ctrl #(.CLKS_PER_BIT(CLKS), .ADDR_W(AW)) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .rx         (rx),
    .clear      (clear),
    .frame_data (frame_data),
    .shift_en   (shift_en),
    .shift_bit  (shift_bit),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .busy       (busy),
    .full       (full),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // Attached frame shift register: LSB-first shift into the MSB, output registered once more.
  logic [9:0] sr   = '0;
  logic [9:0] sr_q = '0;
  always @(posedge clk) begin
    if (shift_en) sr <= {shift_bit, sr[9:1]};
    sr_q <= sr;
  end
  assign frame_data = sr_q[8:1];

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  int se_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int m_addr = 0;
  bit m_full = 0, m_ovf = 0, m_ferr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count shift pulses and match every RAM write against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) se_cnt++;
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", {31'd0, ram_we}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wr_addr_data", {22'd0, ram_addr, ram_data}, {22'd0, mon_exp});
        end
      end
    end
  end

  // Frame-level reference: a good frame lands at the next free slot or is dropped when full.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) begin
      m_ferr = 1;
    end else if (m_full) begin
      m_ovf = 1;
    end else begin
      exp_q.push_back({AW'(m_addr), d});
      if (m_addr == DEPTH - 1) m_full = 1;
      else                     m_addr++;
    end
  endtask

  task automatic model_clear();
    m_addr = 0; m_full = 0; m_ovf = 0; m_ferr = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(CLKS);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 4 * CLKS) begin
      step(1);
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_addr"}, {30'd0, ram_addr}, m_addr);
    check({tag, "_full"}, {31'd0, full}, {31'd0, m_full});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, m_ferr});
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input bit wait_end);
    int se0;
    se0 = se_cnt;
    model_frame(d, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rx = 1'b1;
    step(gap);
    if (wait_end) begin
      wait_idle();
      check("frame_shifts", se_cnt - se0, 10);
      check_flags("frame");
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    model_clear();
    check_flags("clear");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_shift_en"}, {31'd0, shift_en}, 0);
    check({tag, "_shift_bit"}, {31'd0, shift_bit}, 0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 0);
    check({tag, "_ram_addr"}, {30'd0, ram_addr}, 0);
    check({tag, "_ram_data"}, {24'd0, ram_data}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_full"}, {31'd0, full}, 0);
    check({tag, "_ovf"}, {31'd0, overflow}, 0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int se0;
    int k;
    logic [7:0] d;
    logic stop;

    // Reset values
    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    step(4);
    check_all_zero("post_reset");

    // Good frame
    send_frame(8'hA5, 1'b1, 4, 1'b1);

    // Start-bit glitch
    se0 = se_cnt;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2 * CLKS);
    check("glitch_shifts", se_cnt - se0, 0);
    check("glitch_busy", {31'd0, busy}, 0);
    check_flags("glitch");

    // Bad stop bit, sticky until clear
    send_frame(8'h3C, 1'b0, 4, 1'b1);
    step(3 * CLKS);
    check("ferr_sticky", {31'd0, frame_err}, 1);
    do_clear();

    // Fill the RAM and overflow it
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 4, 1'b1);

    // Reset in the middle of the 5th data bit
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    step(CLKS / 2);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    rx = 1'b1;
    step(3);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    step(4);
    send_frame(8'h7E, 1'b1, 4, 1'b1);

    // Randomised frames, including one back-to-back pair
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      if (i == 5) begin
        send_frame(d, 1'b1, 0, 1'b0);
        send_frame(8'($urandom_range(0, 255)), stop, 3, 1'b1);
      end else begin
        send_frame(d, stop, $urandom_range(2, 12), 1'b1);
      end
    end
    do_clear();

    // Break: line held low for many bit times
    se0 = se_cnt;
    rx = 1'b0;
    step(30 * CLKS);
    m_ferr = 1;
    check("break_shifts", se_cnt - se0, 10);
    check("break_busy", {31'd0, busy}, 0);
    check_flags("break");
    rx = 1'b1;
    step(4);
    send_frame(8'hC3, 1'b1, 4, 1'b1);

    // Clear landing on the WRITE cycle of a good frame
    send_frame(8'h5A, 1'b0, 4, 1'b1);
    se0 = se_cnt;
    d = 8'h11;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    rx = 1'b1;
    k = 0;
    while (se_cnt < se0 + 10 && k < 2 * CLKS) begin
      step(1);
      k++;
    end
    check("clrw_shifts", se_cnt - se0, 10);
    step(2);
    clear = 1'b1;
    #1;
    check("clrw_ram_we", {31'd0, ram_we}, 0);
    check("clrw_busy", {31'd0, busy}, 1);
    step(1);
    clear = 1'b0;
    model_clear();
    check_flags("clrw");
    step(CLKS);
    wait_idle();
    check_flags("clrw_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
